// File: rtl/btn_conditioner.sv
// Multi-channel push-button front end: synchronise, debounce, and emit a clean
// level plus press/release strobes, with optional per-channel auto-repeat.
module btn_conditioner #(
  parameter int N_BTN           = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 65000,
  parameter int REPEAT_DELAY    = 26000000,
  parameter int REPEAT_PERIOD   = 6500000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_BTN-1:0]   btn_raw,
  input  logic [N_BTN-1:0]   repeat_en,
  output logic [N_BTN-1:0]   btn_level,
  output logic [N_BTN-1:0]   btn_press,
  output logic [N_BTN-1:0]   btn_release,
  output logic [2*N_BTN-1:0] state_dbg
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    HELD_DELAY  = 2'd1,
    HELD_REPEAT = 2'd2
  } state_t;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic [DW-1:0]          dcnt;
    logic [RW-1:0]          rcnt;
    logic                   level;
    logic                   press;
    logic                   rel;
    logic                   accept;
    state_t                 state;

    assign s      = sync[SYNC_STAGES-1];
    assign accept = (s != level) && (dcnt == DEB_LAST);

    // A HELD state implies level=1, so an accepted change there is always a release.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync  <= '0;
        dcnt  <= '0;
        rcnt  <= '0;
        level <= 1'b0;
        press <= 1'b0;
        rel   <= 1'b0;
        state <= RELEASED;
      end else begin
        sync  <= {sync[SYNC_STAGES-2:0], btn_raw[i]};
        press <= 1'b0;
        rel   <= 1'b0;

        if (s == level) begin
          dcnt <= '0;
        end else if (accept) begin
          level <= s;
          dcnt  <= '0;
        end else begin
          dcnt <= dcnt + 1'b1;
        end

        case (state)
          RELEASED: begin
            rcnt <= '0;
            if (accept && s) begin
              press <= 1'b1;
              state <= HELD_DELAY;
            end
          end
          HELD_DELAY: begin
            if (accept) begin
              rel   <= 1'b1;
              rcnt  <= '0;
              state <= RELEASED;
            end else if (!repeat_en[i]) begin
              rcnt <= '0;
            end else if (rcnt == DLY_LAST) begin
              press <= 1'b1;
              rcnt  <= '0;
              state <= HELD_REPEAT;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
          HELD_REPEAT: begin
            if (accept) begin
              rel   <= 1'b1;
              rcnt  <= '0;
              state <= RELEASED;
            end else if (!repeat_en[i]) begin
              rcnt  <= '0;
              state <= HELD_DELAY;
            end else if (rcnt == PER_LAST) begin
              press <= 1'b1;
              rcnt  <= '0;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
          default: begin
            rcnt  <= '0;
            state <= RELEASED;
          end
        endcase
      end
    end

    assign btn_level[i]         = level;
    assign btn_press[i]         = press;
    assign btn_release[i]       = rel;
    assign state_dbg[2*i +: 2]  = state;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: a window/arithmetic model checked every
// cycle, plus hand-timed strobe expectations for each scenario.
module tb_btn_conditioner;
  localparam int N  = 3;
  localparam int SS = 2;
  localparam int DC = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   btn_raw;
  logic [N-1:0]   repeat_en;
  logic [N-1:0]   btn_level;
  logic [N-1:0]   btn_press;
  logic [N-1:0]   btn_release;
  logic [2*N-1:0] state_dbg;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit run_cmp  = 1'b0;

  always #5 clk = ~clk;

  btn_conditioner #(
    .N_BTN(N), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .repeat_en(repeat_en),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .state_dbg(state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Model: a level flips once the last DC synchronised samples all disagree
  // with it; repeats fall at RD, RD+RP, ... consecutive enabled held cycles.
  logic [N-1:0] raw_q[$];
  logic [N-1:0] s_q[$];
  logic [N-1:0] m_level, m_press, m_rel, m_s;
  int           en_run[N];
  bit           flip;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      raw_q.delete();
      s_q.delete();
      repeat (SS) raw_q.push_back('0);
      repeat (DC) s_q.push_back('0);
      m_level = '0;
      m_press = '0;
      m_rel   = '0;
      for (int c = 0; c < N; c++) en_run[c] = 0;
    end else begin
      cyc++;
      m_s = raw_q.pop_front();
      raw_q.push_back(btn_raw);
      void'(s_q.pop_front());
      s_q.push_back(m_s);
      m_press = '0;
      m_rel   = '0;
      for (int c = 0; c < N; c++) begin
        flip = 1'b1;
        for (int k = 0; k < DC; k++) if (s_q[k][c] == m_level[c]) flip = 1'b0;
        if (flip) begin
          m_level[c] = ~m_level[c];
          if (m_level[c]) m_press[c] = 1'b1;
          else            m_rel[c]   = 1'b1;
          en_run[c] = 0;
        end else if (m_level[c]) begin
          if (!repeat_en[c]) en_run[c] = 0;
          else begin
            en_run[c]++;
            if (en_run[c] == RD || (en_run[c] > RD && (en_run[c] - RD) % RP == 0))
              m_press[c] = 1'b1;
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst === 1'b1 && run_cmp) begin
      check("model_level", btn_level, m_level);
      check("model_press", btn_press, m_press);
      check("model_release", btn_release, m_rel);
      check("exclusive", btn_press & btn_release, '0);
    end
  end

  task automatic advance(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Strobe must stay low on mask for n-1 edges and equal mask on edge n.
  task automatic expect_strobe(input bit rel, input logic [N-1:0] mask, input int n,
                               input string name);
    int           early;
    logic [N-1:0] v;
    early = 0;
    v     = '0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      v = (rel ? btn_release : btn_press) & mask;
      if (k < n && v != '0) early++;
    end
    check({name, "_early"}, early, 0);
    check({name, "_at"}, v, mask);
  endtask

  task automatic quiet(input logic [N-1:0] mask, input int n, input string name);
    int hits;
    hits = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (((btn_press | btn_release) & mask) != '0) hits++;
    end
    check(name, hits, 0);
  endtask

  initial begin
    rst       = 1'b1;
    btn_raw   = '0;
    repeat_en = '0;
    #2 rst = 1'b0;
    #1;
    check("reset_level", btn_level, 0);
    check("reset_press", btn_press, 0);
    check("reset_release", btn_release, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst     = 1'b1;
    run_cmp = 1'b1;
    advance(3);

    // Clean press/release on ch0, no repeat.
    @(negedge clk) btn_raw[0] = 1'b1;
    expect_strobe(1'b0, 3'b001, 6, "t1_press");
    check("t1_level_high", btn_level[0], 1);
    quiet(3'b001, 14, "t1_no_repeat");
    @(negedge clk) btn_raw[0] = 1'b0;
    expect_strobe(1'b1, 3'b001, 6, "t1_release");
    check("t1_level_low", btn_level[0], 0);
    advance(3);

    // Bounce on ch1, then a lone 3-cycle glitch.
    @(negedge clk) btn_raw[1] = 1'b1;
    @(negedge clk) btn_raw[1] = 1'b0;
    @(negedge clk) btn_raw[1] = 1'b1;
    @(negedge clk) btn_raw[1] = 1'b0;
    @(negedge clk) btn_raw[1] = 1'b1;
    expect_strobe(1'b0, 3'b010, 6, "t2_bounce_press");
    advance(3);
    @(negedge clk) btn_raw[1] = 1'b0;
    expect_strobe(1'b1, 3'b010, 6, "t2_release");
    advance(2);
    @(negedge clk) btn_raw[1] = 1'b1;
    repeat (3) @(negedge clk);
    btn_raw[1] = 1'b0;
    quiet(3'b010, 12, "t2_glitch_rejected");
    check("t2_glitch_level", btn_level[1], 0);

    // Auto-repeat on ch2; release lands on a would-be repeat edge.
    @(negedge clk);
    repeat_en[2] = 1'b1;
    btn_raw[2]   = 1'b1;
    expect_strobe(1'b0, 3'b100, 6, "t3_accept");
    expect_strobe(1'b0, 3'b100, RD, "t3_first_repeat");
    for (int k = 0; k < 10; k++) expect_strobe(1'b0, 3'b100, RP, "t3_repeat");
    @(negedge clk) btn_raw[2] = 1'b0;
    expect_strobe(1'b1, 3'b100, 6, "t3_release");
    check("t3_no_press_on_release", btn_press[2], 0);
    advance(3);

    // Repeat enable toggled while held restarts the full delay.
    @(negedge clk) btn_raw[2] = 1'b1;
    expect_strobe(1'b0, 3'b100, 6, "t4_accept");
    expect_strobe(1'b0, 3'b100, RD, "t4_first_repeat");
    advance(2);
    @(negedge clk) repeat_en[2] = 1'b0;
    quiet(3'b100, 8, "t4_paused");
    @(negedge clk) repeat_en[2] = 1'b1;
    expect_strobe(1'b0, 3'b100, RD, "t4_restart");
    @(negedge clk);
    btn_raw[2]   = 1'b0;
    repeat_en[2] = 1'b0;
    expect_strobe(1'b1, 3'b100, 6, "t4_release");
    advance(3);

    // Asynchronous reset while ch0 is repeating, button kept held.
    @(negedge clk);
    repeat_en[0] = 1'b1;
    btn_raw[0]   = 1'b1;
    expect_strobe(1'b0, 3'b001, 6, "t5_accept");
    expect_strobe(1'b0, 3'b001, RD, "t5_repeat");
    #1 rst = 1'b0;
    #1;
    check("t5_async_level", btn_level, 0);
    check("t5_async_press", btn_press, 0);
    check("t5_async_release", btn_release, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    expect_strobe(1'b0, 3'b001, 6, "t5_redetect");
    @(negedge clk);
    btn_raw[0]   = 1'b0;
    repeat_en[0] = 1'b0;
    expect_strobe(1'b1, 3'b001, 6, "t5_release");
    advance(3);

    // Independence: ch0 and ch1 pressed together, released at different times.
    @(negedge clk) btn_raw[1:0] = 2'b11;
    expect_strobe(1'b0, 3'b011, 6, "t6_press_both");
    advance(4);
    @(negedge clk) btn_raw[1] = 1'b0;
    expect_strobe(1'b1, 3'b010, 6, "t6_release_ch1");
    check("t6_ch0_still_held", btn_level[0], 1);
    @(negedge clk) btn_raw[0] = 1'b0;
    expect_strobe(1'b1, 3'b001, 6, "t6_release_ch0");
    advance(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
